dmem_responder: RTL and testbench

//  Data-memory responder: the memory side of the CPU load/store port.

---
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store port between the CPU core (master) and the data-memory responder (slave).
// Carries a request channel and a response channel, each with its own valid/ready handshake.
interface dmem_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding word load/store with optional wait states.
// Optional feature macro DMEM_RANGE_CHECK_EN: flag addresses >= DEPTH as errors instead of aliasing.
module dmem_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt_q, cnt_next;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               req_ready_q, rsp_valid_q;
    logic               req_ready_d, rsp_valid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_d;
    logic               capture;
    logic               accept;
    logic               wr_en;
    logic               cur_we;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  mem [DEPTH];

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(32'(a) % DEPTH);
    endfunction

`ifdef DMEM_RANGE_CHECK_EN
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction
`endif

    assign accept   = bus.req_valid && req_ready_q;
    // With zero wait states RESP is entered on the accept edge, before fields are captured
    assign cur_we   = (state == ST_IDLE) ? bus.req_we   : we_q;
    assign cur_addr = (state == ST_IDLE) ? bus.req_addr : addr_q;

`ifdef DMEM_RANGE_CHECK_EN
    assign wr_en = accept && bus.req_we && in_range(bus.req_addr);
`else
    assign wr_en = accept && bus.req_we;
`endif

    // Storage: committed at the accept edge, lane by lane; never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (bus.req_be[0]) mem[to_idx(bus.req_addr)][7:0]        <= bus.req_wdata[7:0];
            if (bus.req_be[1]) mem[to_idx(bus.req_addr)][DATA_W-1:8] <= bus.req_wdata[DATA_W-1:8];
        end
    end

    // State register, wait counter and captured request fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
            if (accept) begin
                we_q   <= bus.req_we;
                addr_q <= bus.req_addr;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_next = ST_RESP;
                else             cnt_next   = cnt_q - CNT_W'(1);
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered handshake and response fields
    always_comb begin
        req_ready_d = (state_next == ST_IDLE);
        rsp_valid_d = (state == ST_RESP) && (state_next == ST_RESP);
        capture     = (state != ST_RESP) && (state_next == ST_RESP);
        rdata_d     = cur_we ? '0 : mem[to_idx(cur_addr)];
        err_d       = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        if (!in_range(cur_addr)) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
`endif
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
`endif

    // Output registers; response fields only change on entry to RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            if (capture) begin
                rdata_q <= rdata_d;
`ifdef DMEM_RANGE_CHECK_EN
                err_q   <= err_d;
`endif
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one zero-wait instance (DEPTH=200) and one 3-wait instance.
// Expectations for the out-of-range cases follow DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dmem_if bus0 ();
    dmem_if bus3 ();

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    dmem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    virtual dmem_if vif;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction: request, latency, response contents, optional backpressure
    task automatic xfer(input bit sel, input bit we, input logic [7:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input logic [15:0] exp_rdata, input bit exp_err,
                        input int hold);
        int   k;
        int   lat_exp;
        bit   busy_rdy;
        exp_t e;
        if (sel) vif = bus3;
        else     vif = bus0;
        lat_exp = sel ? 5 : 2;
        @(negedge clk);
        vif.req_we    = we;
        vif.req_addr  = addr;
        vif.req_wdata = wdata;
        vif.req_be    = be;
        vif.req_valid = 1'b1;
        vif.rsp_ready = (hold == 0);
        k = 0;
        while (!vif.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 32'(vif.req_ready), 32'd1);
        @(posedge clk);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        @(negedge clk);
        vif.req_valid = 1'b0;
        vif.req_we    = ~we;
        vif.req_addr  = ~addr;
        vif.req_wdata = ~wdata;
        vif.req_be    = ~be;
        k = 1;
        busy_rdy = 1'b0;
        while (!vif.rsp_valid && k < 30) begin
            busy_rdy |= vif.req_ready;
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(lat_exp));
        check("ready_low_in_flight", 32'(busy_rdy), 32'd0);
        e = sb.pop_front();
        check("rdata", 32'(vif.rsp_rdata), 32'(e.rdata));
        check("err", 32'(vif.rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(vif.rsp_valid), 32'd1);
            check("hold_rdata", 32'(vif.rsp_rdata), 32'(e.rdata));
            check("hold_ready", 32'(vif.req_ready), 32'd0);
            @(negedge clk);
        end
        vif.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_valid", 32'(vif.rsp_valid), 32'd0);
        check("done_ready", 32'(vif.req_ready), 32'd1);
        vif.rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        bit          bad;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_be = '0;   bus0.rsp_ready = 1'b0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0;
        bus3.req_wdata = '0;   bus3.req_be = '0;   bus3.rsp_ready = 1'b0;

        // Reset values, during and after reset
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rdata", 32'(bus0.rsp_rdata), 32'd0);
        check("rst_err", 32'(bus0.rsp_err), 32'd0);
        check("rst3_rsp_valid", 32'(bus3.rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("post_rst3_req_ready", 32'(bus3.req_ready), 32'd1);

        // Store then load, zero wait states
        xfer(0, 1, 8'h12, 16'hBEEF, 2'b11, 16'h0000, 0, 0);
        xfer(0, 0, 8'h12, 16'h0000, 2'b00, 16'hBEEF, 0, 0);

        // Byte lanes
        xfer(0, 1, 8'h12, 16'h0055, 2'b01, 16'h0000, 0, 0);
        xfer(0, 0, 8'h12, 16'h0000, 2'b11, 16'hBE55, 0, 0);
        xfer(0, 1, 8'h12, 16'hFFFF, 2'b00, 16'h0000, 0, 0);
        xfer(0, 0, 8'h12, 16'h0000, 2'b01, 16'hBE55, 0, 0);
        xfer(0, 1, 8'h12, 16'hA5C3, 2'b10, 16'h0000, 0, 0);
        xfer(0, 0, 8'h12, 16'h0000, 2'b00, 16'hA555, 0, 0);

        // Wait states and response backpressure
        xfer(1, 1, 8'h12, 16'hCAFE, 2'b11, 16'h0000, 0, 0);
        xfer(1, 0, 8'h12, 16'h0000, 2'b11, 16'hCAFE, 0, 4);
        xfer(1, 1, 8'hFF, 16'h0F0F, 2'b11, 16'h0000, 0, 2);
        xfer(1, 0, 8'hFF, 16'h0000, 2'b11, 16'h0F0F, 0, 0);

        // Addresses at and beyond DEPTH=200
        xfer(0, 1, 8'h00, 16'h1111, 2'b11, 16'h0000, 0, 0);
        xfer(0, 1, 8'hC7, 16'h7777, 2'b11, 16'h0000, 0, 0);
        xfer(0, 0, 8'hC7, 16'h0000, 2'b11, 16'h7777, 0, 0);
`ifdef DMEM_RANGE_CHECK_EN
        xfer(0, 1, 8'hC8, 16'hAAAA, 2'b11, 16'h0000, 1, 0);
        xfer(0, 0, 8'hC8, 16'h0000, 2'b11, 16'h0000, 1, 0);
        xfer(0, 0, 8'h00, 16'h0000, 2'b11, 16'h1111, 0, 0);
`else
        xfer(0, 1, 8'hC8, 16'hAAAA, 2'b11, 16'h0000, 0, 0);
        xfer(0, 0, 8'hC8, 16'h0000, 2'b11, 16'hAAAA, 0, 0);
        xfer(0, 0, 8'h00, 16'h0000, 2'b11, 16'hAAAA, 0, 0);
`endif

        // Random in-range store/load pairs
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(1, 199));
            d = 16'($urandom);
            xfer(0, 1, a, d, 2'b11, 16'h0000, 0, 0);
            xfer(0, 0, a, 16'h0000, 2'b11, d, 0, 0);
        end

        // Reset during WAIT: accepted store survives, response is dropped
        xfer(1, 1, 8'h40, 16'h1234, 2'b11, 16'h0000, 0, 0);
        @(negedge clk);
        bus3.req_we = 1'b1; bus3.req_addr = 8'h41; bus3.req_wdata = 16'h5678;
        bus3.req_be = 2'b11; bus3.req_valid = 1'b1; bus3.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.req_valid = 1'b0;
        check("wait_state_ready", 32'(bus3.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus3.rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(bus3.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bad |= bus3.rsp_valid;
        end
        bus3.rsp_ready = 1'b0;
        check("after_rst_no_valid", 32'(bad), 32'd0);
        check("after_rst_ready", 32'(bus3.req_ready), 32'd1);
        xfer(1, 0, 8'h41, 16'h0000, 2'b11, 16'h5678, 0, 0);
        xfer(1, 0, 8'h40, 16'h0000, 2'b11, 16'h1234, 0, 0);
        xfer(0, 0, 8'hC7, 16'h0000, 2'b11, 16'h7777, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
